mmio_io_ctrl: RTL and testbench

Memory-mapped I/O controller on the core's data-memory port, decoded when the execute-stage byte address has `addr[31:28] == 4'b1000`. Provides parametrised-depth TX and RX byte FIFOs in front of the on-chip UART, sticky overflow flags, and free-running cycle and retired-instruction counters. Read data is registered, so it returns in the same cycle as dmem/bios read data and feeds the load-select/write-back path unchanged.

---
 rtl/mmio_io_ctrl_if.sv | 11 +
 rtl/mmio_io_ctrl.sv | 139 +++++++++++++
 tb/tb_mmio_io_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_io_ctrl_if.sv
// CPU data-memory side of the MMIO block: address/strobes in, registered load data out.
interface mmio_io_ctrl_if;
   logic [31:0] addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (output addr, rd_en, wr_en, wr_data, input  rd_data);
   modport slave  (input  addr, rd_en, wr_en, wr_data, output rd_data);
endinterface

// File: rtl/mmio_io_ctrl.sv
// MMIO controller: UART TX/RX byte FIFOs, sticky overflow flags, cycle and
// retired-instruction counters, with a registered read port aligned to dmem timing.
module mmio_io_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                clk,
   input  logic                rst,
   mmio_io_ctrl_if.slave       bus,
   input  logic                inst_retired,
   output logic [7:0]          uart_tx_data,
   output logic                uart_tx_valid,
   input  logic                uart_tx_ready,
   input  logic [7:0]          uart_rx_data,
   input  logic                uart_rx_valid,
   output logic                uart_rx_ready
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [7:0] {
      OFF_STATUS  = 8'h00,
      OFF_RX_DATA = 8'h04,
      OFF_TX_DATA = 8'h08,
      OFF_CYCLE   = 8'h10,
      OFF_INST    = 8'h14,
      OFF_CNT_RST = 8'h18
   } reg_off_e;

   logic [7:0]           offset;
   logic                 hit, rd_sel, wr_sel;
   logic [7:0]           tx_mem [FIFO_DEPTH];
   logic [7:0]           rx_mem [FIFO_DEPTH];
   logic [PW-1:0]        tx_wp, tx_rp, rx_wp, rx_rp;
   logic [CW-1:0]        tx_cnt, rx_cnt;
   logic                 tx_full, tx_empty, rx_full, rx_empty;
   logic                 tx_push, tx_pop, tx_wr, tx_ovf_set;
   logic                 rx_pop, rx_wr, rx_ovf_set;
   logic                 cnt_clr, tx_ovf, rx_ovf;
   logic [CNT_WIDTH-1:0] cycle_cnt, inst_cnt, cycle_now;
   logic [31:0]          rd_mux;
   logic                 unused_bits;

   assign offset = bus.addr[7:0];
   assign hit    = bus.addr[31:28] == 4'b1000;
   assign rd_sel = hit && bus.rd_en;
   assign wr_sel = hit && bus.wr_en;

   assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
   assign tx_empty = tx_cnt == '0;
   assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
   assign rx_empty = rx_cnt == '0;

   // A full FIFO still accepts a push when the same edge pops an entry.
   assign tx_pop     = uart_tx_valid && uart_tx_ready;
   assign tx_push    = wr_sel && offset == OFF_TX_DATA;
   assign tx_wr      = tx_push && (!tx_full || tx_pop);
   assign tx_ovf_set = tx_push && !tx_wr;
   assign rx_pop     = rd_sel && offset == OFF_RX_DATA && !rx_empty;
   assign rx_wr      = uart_rx_valid && (!rx_full || rx_pop);
   assign rx_ovf_set = uart_rx_valid && !rx_wr;
   assign cnt_clr    = wr_sel && offset == OFF_CNT_RST;

   assign uart_tx_valid = !tx_empty && !rst;
   assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp];
   assign uart_rx_ready = 1'b1;

   // NOTE: FIFO storage has no reset; pointers and counts define validity, so
   // stale contents are never observable and the arrays map onto plain RAM.
   always_ff @(posedge clk) begin
      if (tx_wr) tx_mem[tx_wp] <= bus.wr_data[7:0];
      if (rx_wr) rx_mem[rx_wp] <= uart_rx_data;
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wp     <= '0;
         tx_rp     <= '0;
         tx_cnt    <= '0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         rx_cnt    <= '0;
         tx_ovf    <= 1'b0;
         rx_ovf    <= 1'b0;
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else begin
         if (tx_wr)  tx_wp <= tx_wp + PW'(1);
         if (tx_pop) tx_rp <= tx_rp + PW'(1);
         if (rx_wr)  rx_wp <= rx_wp + PW'(1);
         if (rx_pop) rx_rp <= rx_rp + PW'(1);
         tx_cnt <= tx_cnt + CW'(tx_wr) - CW'(tx_pop);
         rx_cnt <= rx_cnt + CW'(rx_wr) - CW'(rx_pop);
         if (cnt_clr) begin
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            cycle_cnt <= '0;
            inst_cnt  <= '0;
         end else begin
            tx_ovf    <= tx_ovf | tx_ovf_set;
            rx_ovf    <= rx_ovf | rx_ovf_set;
            cycle_cnt <= cycle_now;
            if (inst_retired) inst_cnt <= inst_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // A cycle-count read includes the sampling edge itself: first edge after a clear reads 1.
   assign cycle_now = cycle_cnt + CNT_WIDTH'(1);

   // NOTE: rd_mux gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rd_mux = '0;
      case (offset)
         OFF_STATUS: begin
            rd_mux[0]       = !tx_full;
            rd_mux[1]       = !rx_empty;
            rd_mux[2]       = rx_ovf;
            rd_mux[3]       = tx_ovf;
            rd_mux[8 +: CW]  = tx_cnt;
            rd_mux[16 +: CW] = rx_cnt;
         end
         OFF_RX_DATA: rd_mux[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rp];
         OFF_CYCLE:   rd_mux[CNT_WIDTH-1:0] = cycle_now;
         OFF_INST:    rd_mux[CNT_WIDTH-1:0] = inst_cnt;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)         bus.rd_data <= '0;
      else if (rd_sel) bus.rd_data <= rd_mux;
   end

   assign unused_bits = ^{bus.addr[27:8], bus.wr_data[31:8]};
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Self-checking bench for mmio_io_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based model of the register map.
module tb_mmio_io_ctrl;
   localparam int DEPTH = 8;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam logic [31:0] A_STATUS  = BASE | 32'h00;
   localparam logic [31:0] A_RX      = BASE | 32'h04;
   localparam logic [31:0] A_TX      = BASE | 32'h08;
   localparam logic [31:0] A_CYCLE   = BASE | 32'h10;
   localparam logic [31:0] A_INST    = BASE | 32'h14;
   localparam logic [31:0] A_CNT_RST = BASE | 32'h18;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inst_retired = 1'b0;
   logic [7:0] uart_tx_data;
   logic       uart_tx_valid;
   logic       uart_tx_ready = 1'b0;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_rx_valid = 1'b0;
   logic       uart_rx_ready;

   mmio_io_ctrl_if bus ();

   mmio_io_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .inst_retired  (inst_retired),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model
   logic [7:0]  m_tx_q[$];
   logic [7:0]  m_rx_q[$];
   bit          m_tx_ovf, m_rx_ovf;
   int unsigned m_inst, edge_num, clear_edge;
   logic [31:0] exp_rd;
   bit          tx_rdy_level;

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = m_tx_q.size() < DEPTH;
      s[1]     = m_rx_q.size() != 0;
      s[2]     = m_rx_ovf;
      s[3]     = m_tx_ovf;
      s[15:8]  = 8'(m_tx_q.size());
      s[23:16] = 8'(m_rx_q.size());
      return s;
   endfunction

   // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
   task automatic cycle(input bit r_v, input bit w_v, input logic [31:0] a, input logic [31:0] d,
                        input bit rxv, input logic [7:0] rxd, input bit txr, input bit inst_v,
                        input bit rst_v);
      bit sel, rx_pop, tx_pop, tx_push, clr, rx_full_pre, tx_full_pre;
      logic [7:0] off;
      rst = rst_v; bus.rd_en = r_v; bus.wr_en = w_v; bus.addr = a; bus.wr_data = d;
      uart_rx_valid = rxv; uart_rx_data = rxd; uart_tx_ready = txr; inst_retired = inst_v;
      @(posedge clk);
      edge_num++;
      if (rst_v) begin
         m_tx_q.delete(); m_rx_q.delete();
         m_tx_ovf = 0; m_rx_ovf = 0; m_inst = 0; exp_rd = '0; clear_edge = edge_num;
      end else begin
         sel = a[31:28] == 4'h8;
         off = a[7:0];
         if (r_v && sel) begin
            case (off)
               8'h00: exp_rd = model_status();
               8'h04: exp_rd = (m_rx_q.size() != 0) ? {24'h0, m_rx_q[0]} : 32'h0;
               8'h10: exp_rd = edge_num - clear_edge;
               8'h14: exp_rd = m_inst;
               default: exp_rd = 32'h0;
            endcase
         end
         rx_pop      = r_v && sel && off == 8'h04 && m_rx_q.size() != 0;
         tx_push     = w_v && sel && off == 8'h08;
         clr         = w_v && sel && off == 8'h18;
         tx_pop      = txr && m_tx_q.size() != 0;
         tx_full_pre = m_tx_q.size() == DEPTH;
         rx_full_pre = m_rx_q.size() == DEPTH;
         if (tx_pop) void'(m_tx_q.pop_front());
         if (tx_push) begin
            if (!tx_full_pre || tx_pop) m_tx_q.push_back(d[7:0]);
            else m_tx_ovf = 1;
         end
         if (rx_pop) void'(m_rx_q.pop_front());
         if (rxv) begin
            if (!rx_full_pre || rx_pop) m_rx_q.push_back(rxd);
            else m_rx_ovf = 1;
         end
         if (clr) begin
            m_tx_ovf = 0; m_rx_ovf = 0; m_inst = 0; clear_edge = edge_num;
         end else if (inst_v) m_inst++;
      end
      @(negedge clk);
   endtask

   task automatic idle();                         cycle(0, 0, 32'h0, 32'h0, 0, 8'h0, tx_rdy_level, 0, 0); endtask
   task automatic rd(input logic [31:0] a);       cycle(1, 0, a, 32'h0, 0, 8'h0, tx_rdy_level, 0, 0); endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d); cycle(0, 1, a, d, 0, 8'h0, tx_rdy_level, 0, 0); endtask
   task automatic rx_push(input logic [7:0] b);   cycle(0, 0, 32'h0, 32'h0, 1, b, tx_rdy_level, 0, 0); endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 32'h0, 0, 8'h0, 0, 0, 1);
      checks++; if (uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_in_reset: got %b want 1", uart_rx_ready); end
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
      checks++; if (uart_tx_valid !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: valid %b data %h want 0/00", uart_tx_valid, uart_tx_data); end
      rd(A_STATUS);
      checks++; if (bus.rd_data !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h want 00000001", bus.rd_data); end
      idle(); idle(); idle();
      rd(A_CYCLE);
      checks++; if (bus.rd_data !== 32'd5) begin errors++; $display("FAIL reset_cycle_cnt: got %0d want 5", bus.rd_data); end
   endtask

   task automatic test_tx_overflow();
      tx_rdy_level = 0;
      for (int i = 0; i < 9; i++) wr(A_TX, 32'h41 + i);
      rd(A_STATUS);
      checks++; if (bus.rd_data !== 32'h0000_0808) begin errors++; $display("FAIL tx_full_status: got %h want 00000808", bus.rd_data); end
      tx_rdy_level = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'(8'h41 + i)) begin
            errors++; $display("FAIL tx_order[%0d]: valid %b data %h want 1/%h", i, uart_tx_valid, uart_tx_data, 8'(8'h41 + i));
         end
         idle();
      end
      checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: valid %b want 0", uart_tx_valid); end
   endtask

   task automatic test_rx_path();
      logic [31:0] want [3] = '{32'h55, 32'hAA, 32'h00};
      rx_push(8'h55); rx_push(8'hAA);
      rd(A_STATUS);
      checks++; if (bus.rd_data[1] !== 1'b1) begin errors++; $display("FAIL rx_nonempty: got %b want 1", bus.rd_data[1]); end
      for (int i = 0; i < 3; i++) begin
         rd(A_RX);
         checks++; if (bus.rd_data !== want[i]) begin errors++; $display("FAIL rx_read[%0d]: got %h want %h", i, bus.rd_data, want[i]); end
      end
      rd(A_STATUS);
      checks++; if (bus.rd_data[1] !== 1'b0) begin errors++; $display("FAIL rx_empty_after: got %b want 0", bus.rd_data[1]); end
   endtask

   task automatic test_rx_full();
      logic [7:0] vals [DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         vals[i] = 8'($urandom_range(0, 255));
         rx_push(vals[i]);
      end
      rd(A_STATUS);
      checks++; if (bus.rd_data[23:16] !== 8'd8 || bus.rd_data[2] !== 1'b0) begin errors++; $display("FAIL rx_fill: count %0d ovf %b want 8/0", bus.rd_data[23:16], bus.rd_data[2]); end
      cycle(1, 0, A_RX, 32'h0, 1, 8'h99, tx_rdy_level, 0, 0);
      checks++; if (bus.rd_data !== {24'h0, vals[0]}) begin errors++; $display("FAIL rx_full_pop: got %h want %h", bus.rd_data, vals[0]); end
      rd(A_STATUS);
      checks++; if (bus.rd_data[23:16] !== 8'd8 || bus.rd_data[2] !== 1'b0) begin errors++; $display("FAIL rx_pop_push: count %0d ovf %b want 8/0", bus.rd_data[23:16], bus.rd_data[2]); end
      rx_push(8'h77);
      rd(A_STATUS);
      checks++; if (bus.rd_data[2] !== 1'b1) begin errors++; $display("FAIL rx_overflow: got %b want 1", bus.rd_data[2]); end
      checks++; if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL rx_overflow_model: got %h want %h", bus.rd_data, exp_rd); end
   endtask

   task automatic test_counters();
      wr(A_CNT_RST, 32'hDEAD_BEEF);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 32'h0, 32'h0, 0, 8'h0, tx_rdy_level, 1, 0);
         if (i % 3 == 0) idle();
      end
      rd(A_INST);
      checks++; if (bus.rd_data !== 32'd10) begin errors++; $display("FAIL inst_cnt: got %0d want 10", bus.rd_data); end
      tx_rdy_level = 0;
      for (int i = 0; i < 9; i++) wr(A_TX, 32'($urandom));
      rx_push(8'h01);
      rd(A_STATUS);
      checks++; if (bus.rd_data[3:2] !== 2'b11) begin errors++; $display("FAIL both_ovf: got %b want 11", bus.rd_data[3:2]); end
      cycle(0, 1, A_CNT_RST, 32'h0, 1, 8'h02, tx_rdy_level, 1, 0);
      rd(A_INST);
      checks++; if (bus.rd_data !== 32'd0) begin errors++; $display("FAIL inst_after_clear: got %0d want 0", bus.rd_data); end
      rd(A_STATUS);
      checks++; if (bus.rd_data[3:2] !== 2'b00) begin errors++; $display("FAIL ovf_after_clear: got %b want 00", bus.rd_data[3:2]); end
      rd(A_CYCLE);
      checks++; if (bus.rd_data !== 32'd3) begin errors++; $display("FAIL cycle_after_clear: got %0d want 3", bus.rd_data); end
   endtask

   task automatic test_decode();
      logic [31:0] prev;
      rx_push(8'h3C);
      rd(A_STATUS);
      prev = bus.rd_data;
      rd(32'h0000_0004);
      checks++; if (bus.rd_data !== prev) begin errors++; $display("FAIL non_mmio_read: got %h want %h", bus.rd_data, prev); end
      rd(A_STATUS);
      checks++; if (bus.rd_data !== prev) begin errors++; $display("FAIL non_mmio_no_pop: got %h want %h", bus.rd_data, prev); end
      rd(BASE | 32'h0C);
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", bus.rd_data); end
      wr(A_STATUS, 32'hFFFF_FFFF);
      rd(A_TX);
      checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL wo_read: got %h want 0", bus.rd_data); end
      rd(A_STATUS);
      checks++; if (bus.rd_data !== prev) begin errors++; $display("FAIL ro_write: got %h want %h", bus.rd_data, prev); end
   endtask

   task automatic test_random();
      logic [31:0] addrs [8] = '{A_STATUS, A_RX, A_TX, A_CYCLE, A_INST, BASE | 32'h0C, 32'h0000_0008, A_CNT_RST};
      int unsigned pick;
      for (int i = 0; i < 400; i++) begin
         checks++;
         if (uart_tx_valid !== (m_tx_q.size() != 0) ||
             (m_tx_q.size() != 0 && uart_tx_data !== m_tx_q[0])) begin
            errors++; $display("FAIL rand_tx[%0d]: valid %b data %h want %b/%h", i, uart_tx_valid, uart_tx_data,
                               m_tx_q.size() != 0, (m_tx_q.size() != 0) ? m_tx_q[0] : 8'h00);
         end
         pick = $urandom_range(0, 15);
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, addrs[(pick == 15) ? 7 : pick % 7],
               $urandom, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, 0);
         checks++;
         if (bus.rd_data !== exp_rd) begin errors++; $display("FAIL rand_rd[%0d]: got %h want %h", i, bus.rd_data, exp_rd); end
      end
   endtask

   task automatic test_back_to_back_reset();
      tx_rdy_level = 0;
      wr(A_TX, 32'h11); wr(A_TX, 32'h22); rx_push(8'h33);
      cycle(0, 0, 32'h0, 32'h0, 1, 8'h44, 0, 0, 1);
      checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL midop_reset_valid: got %b want 0", uart_tx_valid); end
      rd(A_STATUS);
      checks++; if (bus.rd_data !== 32'h0000_0001) begin errors++; $display("FAIL midop_reset_status: got %h want 00000001", bus.rd_data); end
   endtask

   initial begin
      bus.addr = '0; bus.rd_en = 0; bus.wr_en = 0; bus.wr_data = '0;
      m_tx_ovf = 0; m_rx_ovf = 0; m_inst = 0; edge_num = 0; clear_edge = 0;
      exp_rd = '0; tx_rdy_level = 0;
      @(negedge clk);
      test_reset();
      test_tx_overflow();
      test_rx_path();
      test_rx_full();
      test_counters();
      test_decode();
      test_random();
      test_back_to_back_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
